axis_cacc: RTL and testbench
============================

# axis_cacc

Complex accumulate-and-dump stage for the AXI-Stream DSP chain. It sits directly downstream of the complex multiplier. Each accepted beat carries one complex product, with the real part in the low half and the imaginary part in the high half. The block accumulates products over a frame delimited by `tlast`, then emits one rounded, scaled complex result per frame together with the frame's beat count. Typical uses are correlator and matched-filter sums.

## Interface
- `IN_WIDTH`, 32, width of each input component (real and imaginary), signed.
- `ACC_WIDTH`, 48, width of each accumulator, signed; must be ≥ `IN_WIDTH`.
- `OUT_WIDTH`, 16, width of each output component, signed.
- `SHIFT`, 15, arithmetic right shift applied to the sum at dump; range 0 to `ACC_WIDTH-1`.
- `CNT_WIDTH`, 16, width of the beat counter.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  2*IN_WIDTH  {imag, real} product.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tlast`  in  1  last beat of frame.
- `m_axis_tdata`  out  2*OUT_WIDTH  {imag, real} scaled sum.
- `m_axis_tvalid`  out  1  result valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  always 1 when valid; every result is a one-beat frame.
- `m_axis_tuser`  out  1  saturation flag; at least one component clipped.
- `m_axis_tcount`  out  CNT_WIDTH  number of beats in the dumped frame.

## Operation
- An input beat is accepted when `s_axis_tvalid && s_axis_tready`.
- `s_axis_tready = !m_axis_tvalid || m_axis_tready`. This is combinational from `m_axis_tready`, with a single output register.
- Input components are sign-extended to `ACC_WIDTH`. Accumulation is modulo 2^`ACC_WIDTH` (wraps, no accumulator saturation).
- Accepted beat without `tlast`:
  - `acc_re`/`acc_im` += input;
  - `cnt` += 1, saturating at all-ones.
- Accepted beat with `tlast`:
  - the final sum (`acc` + input) and `cnt+1` are computed;
  - the result is loaded into the output register;
  - `acc` and `cnt` are cleared to 0, so the next beat starts a new frame.
- Scaling, per component:
  - compute `s = (sum + R) >>> SHIFT` in `ACC_WIDTH+1` bits;
  - `R = 2^(SHIFT-1)` for `SHIFT > 0`, else 0 (round half up).
- Output narrowing of `s` to `OUT_WIDTH` is set by the macro below.
- `tuser` is the OR of both components' clip flags.
- The accumulator holds its value while the input is idle or stalled. Frames of any length ≥ 1 are legal.

## Timing
- Latency: the result appears on `m_axis_tvalid` in the cycle after the `tlast` beat is accepted.
- Throughput: one beat per cycle. Back-to-back single-beat frames yield one result per cycle when `m_axis_tready = 1`.
- The output register holds `tdata`, `tuser` and `tcount` stable while `m_axis_tvalid && !m_axis_tready`. During that stall `s_axis_tready = 0`, so no beats are accepted, including non-`tlast` beats.
- Simultaneous output handshake and new `tlast` beat: the old result completes and the new result loads in the same edge.
- Reset, checked on the `aclk` edge while `aresetn = 0`:
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tuser`, `m_axis_tcount` = 0;
  - `m_axis_tlast` = 1;
  - `acc` and `cnt` = 0.
- Reset mid-frame discards the partial sum. A pending unaccepted result is dropped.
- `s_axis_tready` = 1 while in reset and in the first cycle after reset.

## Configuration
- Macro: `AXIS_CACC_SAT_EN`.
- Defined:
  - each component of `s` is clipped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1];
  - `tuser` = 1 if either component clipped.
- Undefined:
  - each component is truncated to its low `OUT_WIDTH` bits (wraps);
  - `m_axis_tuser` is tied to 0.

## Test plan
All scenarios use default parameters.
- **Basic frame:** 3 beats of real = 32768, imag = -32768, `tlast` on the 3rd, `m_axis_tready = 1`.
  - Required: one cycle later `tdata = 0xFFFD_0003`, `tcount = 3`, `tuser = 0`.
- **Rounding:** single-beat frame real = 16384, imag = -16384.
  - Required: real = 1, imag = 0, `tdata = 0x0000_0001`, `tcount = 1`.
- **Saturation:** 2 beats of real = 2^30, imag = -2^30, then `tlast`.
  - With the macro defined: `tdata = 0x8000_7FFF`, `tuser = 1`.
  - Without the macro: `tdata = 0x0000_0000`, `tuser = 0`.
- **Backpressure:** frame completes with `m_axis_tready = 0` for 5 cycles while the next frame's beats are offered.
  - Required: `s_axis_tready = 0` and the output holds stable throughout.
  - After `m_axis_tready` rises, the next frame sums correctly with no beat lost or duplicated.
- **Reset mid-frame:** 2 beats of real = 32768, then `aresetn = 0` for 1 cycle, then a `tlast` beat with real = 32768.
  - Required: `tdata` real = 1, `tcount = 1`.
- **Back-to-back single-beat frames:** 4 frames with real = 32768·k for k = 1..4, `m_axis_tready = 1`.
  - Required: 4 consecutive valid cycles, real = 1, 2, 3, 4, each with `tcount = 1`.

Source files
------------

// File: rtl/axis_cacc.sv
// Complex accumulate-and-dump on AXI-Stream: sums {imag, real} products over a tlast frame
// and emits one rounded, scaled result plus beat count. Define AXIS_CACC_SAT_EN to clip instead of wrap.
module axis_cacc #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 48,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [2*IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [2*OUT_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [CNT_WIDTH-1:0]   m_axis_tcount
);

    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH:0] RND =
        (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RSH) : '0;
`ifdef AXIS_CACC_SAT_EN
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        signed'({{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;
`endif

    // Round half up, then arithmetic shift, one guard bit so sum + R cannot overflow.
    function automatic logic signed [ACC_WIDTH:0] round_shift(input logic signed [ACC_WIDTH-1:0] sum);
        logic signed [ACC_WIDTH:0] ext;
        ext = (ACC_WIDTH+1)'(sum);
        return (ext + RND) >>> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_WIDTH:0] narrow(input logic signed [ACC_WIDTH:0] s);
`ifdef AXIS_CACC_SAT_EN
        if (s > OUT_MAX)
            return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        else if (s < OUT_MIN)
            return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        else
            return {1'b0, s[OUT_WIDTH-1:0]};
`else
        return {1'b0, s[OUT_WIDTH-1:0]};
`endif
    endfunction

    logic signed [ACC_WIDTH-1:0] r_acc_re_p0, r_acc_im_p0;
    logic [CNT_WIDTH-1:0]        r_cnt_p0;
    logic                        r_vld_p1;
    logic [2*OUT_WIDTH-1:0]      r_data_p1;
    logic                        r_user_p1;
    logic [CNT_WIDTH-1:0]        r_cnt_p1;

    logic signed [IN_WIDTH-1:0]  w_raw_re, w_raw_im;
    logic signed [ACC_WIDTH-1:0] w_in_re, w_in_im;
    logic signed [ACC_WIDTH-1:0] w_sum_re, w_sum_im;
    logic [CNT_WIDTH-1:0]        w_cnt_inc;
    logic [OUT_WIDTH:0]          w_res_re, w_res_im;
    logic                        w_accept;

    assign w_raw_re  = s_axis_tdata[IN_WIDTH-1:0];
    assign w_raw_im  = s_axis_tdata[2*IN_WIDTH-1:IN_WIDTH];
    assign w_in_re   = ACC_WIDTH'(w_raw_re);
    assign w_in_im   = ACC_WIDTH'(w_raw_im);
    assign w_sum_re  = r_acc_re_p0 + w_in_re;
    assign w_sum_im  = r_acc_im_p0 + w_in_im;
    assign w_cnt_inc = (&r_cnt_p0) ? r_cnt_p0 : r_cnt_p0 + CNT_WIDTH'(1);
    assign w_res_re  = narrow(round_shift(w_sum_re));
    assign w_res_im  = narrow(round_shift(w_sum_im));

    // Held high during reset so upstream never sees a spurious stall.
    assign s_axis_tready = !aresetn || !r_vld_p1 || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    // Stage p0: accumulate; stage p1: dumped result register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_acc_re_p0 <= '0;
            r_acc_im_p0 <= '0;
            r_cnt_p0    <= '0;
            r_vld_p1    <= 1'b0;
            r_data_p1   <= '0;
            r_user_p1   <= 1'b0;
            r_cnt_p1    <= '0;
        end else begin
            if (m_axis_tready)
                r_vld_p1 <= 1'b0;
            if (w_accept) begin
                if (s_axis_tlast) begin
                    r_acc_re_p0 <= '0;
                    r_acc_im_p0 <= '0;
                    r_cnt_p0    <= '0;
                    r_vld_p1    <= 1'b1;
                    r_data_p1   <= {w_res_im[OUT_WIDTH-1:0], w_res_re[OUT_WIDTH-1:0]};
                    r_user_p1   <= w_res_re[OUT_WIDTH] | w_res_im[OUT_WIDTH];
                    r_cnt_p1    <= w_cnt_inc;
                end else begin
                    r_acc_re_p0 <= w_sum_re;
                    r_acc_im_p0 <= w_sum_im;
                    r_cnt_p0    <= w_cnt_inc;
                end
            end
        end
    end

    assign m_axis_tvalid = r_vld_p1;
    assign m_axis_tdata  = r_data_p1;
    assign m_axis_tuser  = r_user_p1;
    assign m_axis_tcount = r_cnt_p1;
    assign m_axis_tlast  = 1'b1;

endmodule

// File: tb/tb_axis_cacc.sv
// Bench for axis_cacc: directed scenarios plus a randomized run checked against a frame-level model.
module tb_axis_cacc;

    localparam int IW = 32;
    localparam int AW = 48;
    localparam int OW = 16;
    localparam int SH = 15;
    localparam int CW = 16;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [2*IW-1:0] s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [2*OW-1:0] m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic [CW-1:0]   m_axis_tcount;

    int checks = 0;
    int errors = 0;

    axis_cacc #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH), .CNT_WIDTH(CW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tcount(m_axis_tcount)
    );

    always #5 aclk = ~aclk;

    // Frame sum -> {clipped, value}: wrap to accumulator width, round half up, shift, narrow.
    function automatic logic [OW:0] model_scale(input longint sum);
        longint w, s, hi, lo;
        w  = (sum <<< (64 - AW)) >>> (64 - AW);
        s  = (w + ((SH > 0) ? (longint'(1) <<< (SH - 1)) : longint'(0))) >>> SH;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
`ifdef AXIS_CACC_SAT_EN
        if (s > hi) return {1'b1, hi[OW-1:0]};
        if (s < lo) return {1'b1, lo[OW-1:0]};
        return {1'b0, s[OW-1:0]};
`else
        return {1'b0, s[OW-1:0]};
`endif
    endfunction

    task automatic beat(input int re, input int im, input bit last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {im, re};
        s_axis_tlast  = last;
        @(negedge aclk);
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        s_axis_tdata  = {$urandom(), $urandom()};
        repeat (2) @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser got %b want 0", m_axis_tuser); end
        checks++; if (m_axis_tcount !== '0) begin errors++; $display("FAIL rst_tcount got %0d want 0", m_axis_tcount); end
        checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL rst_tlast got %b want 1", m_axis_tlast); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %b want 1", s_axis_tready); end
        idle();
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        #1;
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready got %b want 1", s_axis_tready); end
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL post_rst_tvalid got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_basic();
        m_axis_tready = 1'b1;
        beat(32768, -32768, 1'b0);
        beat(32768, -32768, 1'b0);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", m_axis_tvalid); end
        beat(32768, -32768, 1'b1);
        idle();
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'hFFFD_0003) begin errors++; $display("FAIL basic_tdata got %h want FFFD0003", m_axis_tdata); end
        checks++; if (m_axis_tcount !== 16'd3) begin errors++; $display("FAIL basic_tcount got %0d want 3", m_axis_tcount); end
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL basic_tuser got %b want 0", m_axis_tuser); end
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_rounding();
        beat(16384, -16384, 1'b1);
        idle();
        checks++; if (m_axis_tdata !== 32'h0000_0001) begin errors++; $display("FAIL round_tdata got %h want 00000001", m_axis_tdata); end
        checks++; if (m_axis_tcount !== 16'd1) begin errors++; $display("FAIL round_tcount got %0d want 1", m_axis_tcount); end
    endtask

    task automatic test_saturation();
        logic [2*OW-1:0] exp_d;
        logic            exp_u;
`ifdef AXIS_CACC_SAT_EN
        exp_d = 32'h8000_7FFF; exp_u = 1'b1;
`else
        exp_d = 32'h0000_0000; exp_u = 1'b0;
`endif
        beat(32'sh4000_0000, -32'sh4000_0000, 1'b0);
        beat(32'sh4000_0000, -32'sh4000_0000, 1'b1);
        idle();
        checks++; if (m_axis_tdata !== exp_d) begin errors++; $display("FAIL sat_tdata got %h want %h", m_axis_tdata, exp_d); end
        checks++; if (m_axis_tuser !== exp_u) begin errors++; $display("FAIL sat_tuser got %b want %b", m_axis_tuser, exp_u); end
        checks++; if (m_axis_tcount !== 16'd2) begin errors++; $display("FAIL sat_tcount got %0d want 2", m_axis_tcount); end
    endtask

    task automatic test_backpressure();
        @(negedge aclk);
        m_axis_tready = 1'b0;
        beat(5 * 32768, -2 * 32768, 1'b0);
        beat(5 * 32768, -2 * 32768, 1'b1);
        // Next frame's first beat is offered throughout the stall.
        s_axis_tdata = {32'sd32768, 32'sd98304};
        s_axis_tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_tready[%0d] got %b want 0", i, s_axis_tready); end
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid[%0d] got %b want 1", i, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== 32'hFFFC_000A) begin errors++; $display("FAIL bp_tdata[%0d] got %h want FFFC000A", i, m_axis_tdata); end
            checks++; if (m_axis_tcount !== 16'd2) begin errors++; $display("FAIL bp_tcount[%0d] got %0d want 2", i, m_axis_tcount); end
            @(negedge aclk);
        end
        m_axis_tready = 1'b1;
        #1;
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL bp_release_tready got %b want 1", s_axis_tready); end
        @(negedge aclk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", m_axis_tvalid); end
        beat(4 * 32768, 2 * 32768, 1'b1);
        idle();
        checks++; if (m_axis_tdata !== 32'h0003_0007) begin errors++; $display("FAIL bp_next_tdata got %h want 00030007", m_axis_tdata); end
        checks++; if (m_axis_tcount !== 16'd2) begin errors++; $display("FAIL bp_next_tcount got %0d want 2", m_axis_tcount); end
    endtask

    task automatic test_reset_midframe();
        beat(32768, 0, 1'b0);
        beat(32768, 0, 1'b0);
        idle();
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        beat(32768, 0, 1'b1);
        idle();
        checks++; if (m_axis_tdata !== 32'h0000_0001) begin errors++; $display("FAIL rstmid_tdata got %h want 00000001", m_axis_tdata); end
        checks++; if (m_axis_tcount !== 16'd1) begin errors++; $display("FAIL rstmid_tcount got %0d want 1", m_axis_tcount); end
    endtask

    task automatic test_back_to_back();
        @(negedge aclk);
        for (int k = 1; k <= 4; k++) begin
            beat(32768 * k, 0, 1'b1);
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", k, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== {16'd0, 16'(k)}) begin errors++; $display("FAIL b2b_tdata[%0d] got %h want %h", k, m_axis_tdata, {16'd0, 16'(k)}); end
            checks++; if (m_axis_tcount !== 16'd1) begin errors++; $display("FAIL b2b_tcount[%0d] got %0d want 1", k, m_axis_tcount); end
        end
        idle();
        @(negedge aclk);
    endtask

    task automatic test_random();
        longint          acc_re = 0, acc_im = 0;
        int              cnt = 0;
        bit              pend = 0;
        logic [2*OW-1:0] exp_d = '0;
        logic            exp_u = 1'b0;
        logic [CW-1:0]   exp_c = '0;
        logic [OW:0]     rr, ri;
        int              re, im, ninc;
        bit              v, l, mr, rdy;
        for (int c = 0; c < 600; c++) begin
            mr = ($urandom_range(3) != 0);
            v  = ($urandom_range(9) < 7);
            l  = ($urandom_range(4) == 0);
            re = $urandom();
            im = $urandom();
            if ($urandom_range(1) == 1) begin
                re = re >>> 12;
                im = im >>> 12;
            end
            m_axis_tready = mr;
            s_axis_tvalid = v;
            s_axis_tlast  = l;
            s_axis_tdata  = {im, re};
            #1;
            rdy = !pend || mr;
            checks++; if (s_axis_tready !== rdy) begin errors++; $display("FAIL rnd_tready[%0d] got %b want %b", c, s_axis_tready, rdy); end
            checks++; if (m_axis_tvalid !== pend) begin errors++; $display("FAIL rnd_tvalid[%0d] got %b want %b", c, m_axis_tvalid, pend); end
            if (pend) begin
                checks++; if (m_axis_tdata !== exp_d) begin errors++; $display("FAIL rnd_tdata[%0d] got %h want %h", c, m_axis_tdata, exp_d); end
                checks++; if (m_axis_tuser !== exp_u) begin errors++; $display("FAIL rnd_tuser[%0d] got %b want %b", c, m_axis_tuser, exp_u); end
                checks++; if (m_axis_tcount !== exp_c) begin errors++; $display("FAIL rnd_tcount[%0d] got %0d want %0d", c, m_axis_tcount, exp_c); end
            end
            if (pend && mr) pend = 0;
            if (v && rdy) begin
                acc_re += longint'(re);
                acc_im += longint'(im);
                ninc = (cnt == (1 << CW) - 1) ? cnt : cnt + 1;
                if (l) begin
                    rr    = model_scale(acc_re);
                    ri    = model_scale(acc_im);
                    exp_d = {ri[OW-1:0], rr[OW-1:0]};
                    exp_u = rr[OW] | ri[OW];
                    exp_c = CW'(ninc);
                    pend  = 1;
                    acc_re = 0; acc_im = 0; cnt = 0;
                end else begin
                    cnt = ninc;
                end
            end
            @(negedge aclk);
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        @(negedge aclk);
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
